// File: rtl/n64_vbus_tx.sv
// n64_vbus_tx: N64 multiplexed video bus transmitter; generates line/frame timing
// and serialises one pixel per 4-clock slot as sync word, R, G, B on VD_o.
module n64_vbus_tx #(
    parameter int H_TOTAL   = 773,
    parameter int H_SYNC    = 57,
    parameter int CLAMP_LEN = 32,
    parameter int H_ACT_ST  = 128,
    parameter int H_ACT     = 640,
    parameter int V_TOTAL   = 263,
    parameter int V_SYNC    = 3,
    parameter int V_ACT_ST  = 20,
    parameter int V_ACT     = 240
) (
    input  logic       VCLK,
    input  logic       VRST,
    input  logic       en,
    input  logic [6:0] px_r,
    input  logic [6:0] px_g,
    input  logic [6:0] px_b,
    input  logic       px_valid,
    output logic       px_ready,
    output logic       nVDSYNC_o,
    output logic [6:0] VD_o,
    output logic       frame_st,
    output logic       underrun
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [1:0]    r_phase;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [6:0]    r_r, r_g, r_b, r_vd;
    logic          r_nvdsync, r_fs, r_ur;

    logic [31:0] w_h, w_v;
    logic        w_nhs, w_nvs, w_nclamp, w_ncs, w_active, w_take, w_hwrap, w_vwrap;

    // Widen counters so slot-range bounds compare unsigned without truncation.
    assign w_h      = 32'(r_h);
    assign w_v      = 32'(r_v);
    assign w_nhs    = ~(w_h < H_SYNC);
    assign w_nvs    = ~(w_v < V_SYNC);
    assign w_nclamp = ~((w_h >= H_SYNC) & (w_h < H_SYNC + CLAMP_LEN));
    assign w_ncs    = w_nvs ? w_nhs : ~w_nhs;
    assign w_active = (w_h >= H_ACT_ST) & (w_h < H_ACT_ST + H_ACT) &
                      (w_v >= V_ACT_ST) & (w_v < V_ACT_ST + V_ACT);
    assign w_hwrap  = (w_h == H_TOTAL - 1);
    assign w_vwrap  = (w_v == V_TOTAL - 1);
    assign px_ready = en & (r_phase == 2'd0) & w_active;
    assign w_take   = px_ready & px_valid;

    always_ff @(posedge VCLK or posedge VRST) begin
        if (VRST) begin
            r_phase   <= '0;
            r_h       <= '0;
            r_v       <= '0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_vd      <= '0;
            r_nvdsync <= 1'b1;
            r_fs      <= 1'b0;
            r_ur      <= 1'b0;
        end else if (!en) begin
            r_phase   <= '0;
            r_h       <= '0;
            r_v       <= '0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_vd      <= '0;
            r_nvdsync <= 1'b1;
            r_fs      <= 1'b0;
            r_ur      <= 1'b0;
        end else begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd3) begin
                r_h <= w_hwrap ? '0 : r_h + 1'b1;
                if (w_hwrap)
                    r_v <= w_vwrap ? '0 : r_v + 1'b1;
            end
            case (r_phase)
                2'd0: begin
                    r_nvdsync <= 1'b0;
                    r_vd      <= {3'b000, w_nvs, w_nclamp, w_nhs, w_ncs};
                    r_fs      <= (r_h == '0) & (r_v == '0);
                    // Blank slots and underruns both load zero colour.
                    r_r       <= w_take ? px_r : 7'h00;
                    r_g       <= w_take ? px_g : 7'h00;
                    r_b       <= w_take ? px_b : 7'h00;
                    if (px_ready & ~px_valid)
                        r_ur <= 1'b1;
                end
                2'd1: begin
                    r_nvdsync <= 1'b1;
                    r_vd      <= r_r;
                    r_fs      <= 1'b0;
                end
                2'd2: r_vd <= r_g;
                default: r_vd <= r_b;
            endcase
        end
    end

    assign nVDSYNC_o = r_nvdsync;
    assign VD_o      = r_vd;
    assign frame_st  = r_fs;
    assign underrun  = r_ur;
endmodule
